// File: rtl/hyperram_traffic_gen.sv
// rtl/hyperram_traffic_gen.sv - multi-channel HyperRAM traffic generator and read-back checker
//
// Issues write, read or write-then-verify runs to NUM_CH controller channels
// through a shared ctrl_* command bus with per-channel chip selects. Read-back
// words are checked per channel against the same pattern that was written.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   start_i, abort_i          single-cycle run request / abort
//   cfg_*_i                   run configuration, latched on start
//   ctrl_cs_o                 per-channel command strobe
//   ctrl_mode_o               2'b00 write, 2'b01 read (held between commands)
//   ctrl_addr_o, ctrl_num_words_o, ctrl_latency_o   latched command fields
//   ctrl_wr_data_o, ctrl_wr_data_valid_o             write word stream
//   ctrl_rd_data_i, ctrl_rd_data_valid_i             per-channel read words
//   busy_o, done_o, pass_o, timeout_o                run status
//   err_count_o, first_err_ch_o, first_err_idx_o     error statistics
module hyperram_traffic_gen #(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       CNT_W      = 32,
  parameter int unsigned       GAP_CYCLES = 64,
  parameter longint unsigned   TIMEOUT    = 65536,
  parameter logic [DATA_W-1:0] LFSR_TAPS  = DATA_W'(32'h80200003),
  localparam int unsigned      CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [1:0]               cfg_mode_i,
  input  logic [1:0]               cfg_pattern_i,
  input  logic [DATA_W-1:0]        cfg_seed_i,
  input  logic [NUM_CH-1:0]        cfg_ch_mask_i,
  input  logic [CNT_W-1:0]         cfg_addr_i,
  input  logic [CNT_W-1:0]         cfg_num_words_i,
  input  logic [2:0]               cfg_latency_i,
  output logic [NUM_CH-1:0]        ctrl_cs_o,
  output logic [1:0]               ctrl_mode_o,
  output logic [CNT_W-1:0]         ctrl_addr_o,
  output logic [CNT_W-1:0]         ctrl_num_words_o,
  output logic [2:0]               ctrl_latency_o,
  output logic [DATA_W-1:0]        ctrl_wr_data_o,
  output logic                     ctrl_wr_data_valid_o,
  input  logic [NUM_CH*DATA_W-1:0] ctrl_rd_data_i,
  input  logic [NUM_CH-1:0]        ctrl_rd_data_valid_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [CNT_W-1:0]         err_count_o,
  output logic [CH_W-1:0]          first_err_ch_o,
  output logic [CNT_W-1:0]         first_err_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CMD,
    S_WR_DATA,
    S_GAP,
    S_RD_CMD,
    S_RD_DATA,
    S_FINISH
  } state_t;

  localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  // Pattern sequence: word 0 comes from pat_init, word k+1 = pat_next(word k).
  // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
  function automatic logic [DATA_W-1:0] pat_init(input logic [1:0] p, input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r = s;
    if (p[1] && (s == '0)) r = DATA_W'(1);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] pat_next(input logic [1:0] p, input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    if (p[1])      r = (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
    else if (p[0]) r = x + DATA_W'(1);
    else           r = x;
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          pattern_q, pattern_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [2:0]          lat_q, lat_d;
  logic [1:0]          ctrl_mode_q, ctrl_mode_d;
  logic [DATA_W-1:0]   wr_pat_q, wr_pat_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [15:0]         gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q [NUM_CH];
  logic [CNT_W-1:0]    rd_cnt_d [NUM_CH];
  logic [DATA_W-1:0]   exp_q    [NUM_CH];
  logic [DATA_W-1:0]   exp_d    [NUM_CH];
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [CH_W-1:0]     first_ch_q, first_ch_d;
  logic [CNT_W-1:0]    first_idx_q, first_idx_d;

  logic                all_done;
  logic                ch_err;
  logic                err_hit;
  logic [CH_W-1:0]     hit_ch;
  logic [CNT_W-1:0]    hit_idx;
  logic [CNT_W-1:0]    err_add;
  logic [CNT_W:0]      sat_sum;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pattern_d   = pattern_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    num_d       = num_q;
    lat_d       = lat_q;
    ctrl_mode_d = ctrl_mode_q;
    wr_pat_d    = wr_pat_q;
    wr_cnt_d    = wr_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_count_d = err_count_q;
    first_ch_d  = first_ch_q;
    first_idx_d = first_idx_q;
    ch_err      = 1'b0;
    err_hit     = 1'b0;
    hit_ch      = '0;
    hit_idx     = '0;
    err_add     = '0;
    sat_sum     = '0;
    all_done    = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_cnt_d[i] = rd_cnt_q[i];
      exp_d[i]    = exp_q[i];
      if (mask_q[i] && (rd_cnt_q[i] != num_q)) all_done = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d      = cfg_mode_i;
          pattern_d   = cfg_pattern_i;
          mask_d      = cfg_ch_mask_i;
          addr_d      = cfg_addr_i;
          num_d       = cfg_num_words_i;
          lat_d       = cfg_latency_i;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          err_count_d = '0;
          first_ch_d  = '0;
          first_idx_d = '0;
          wr_cnt_d    = '0;
          wr_pat_d    = pat_init(cfg_pattern_i, cfg_seed_i);
          for (int i = 0; i < NUM_CH; i++) begin
            rd_cnt_d[i] = '0;
            exp_d[i]    = pat_init(cfg_pattern_i, cfg_seed_i);
          end
          if ((cfg_ch_mask_i == '0) || (cfg_num_words_i == '0)) begin
            state_d = S_FINISH;
          end else if (cfg_mode_i == 2'd1) begin
            state_d     = S_RD_CMD;
            ctrl_mode_d = 2'b01;
          end else begin
            state_d     = S_WR_CMD;
            ctrl_mode_d = 2'b00;
          end
        end
      end

      S_WR_CMD: state_d = S_WR_DATA;

      S_WR_DATA: begin
        wr_pat_d = pat_next(pattern_q, wr_pat_q);
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
        if (wr_cnt_q == num_q - CNT_W'(1)) begin
          gap_cnt_d = '0;
          state_d   = (mode_q == 2'd0) ? S_FINISH : S_GAP;
        end
      end

      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 16'd1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d     = S_RD_CMD;
          ctrl_mode_d = 2'b01;
        end
      end

      S_RD_CMD: begin
        tmo_cnt_d = '0;
        state_d   = S_RD_DATA;
      end

      S_RD_DATA: begin
        for (int i = 0; i < NUM_CH; i++) begin
          ch_err = 1'b0;
          if (ctrl_rd_data_valid_i[i] && mask_q[i]) begin
            if (rd_cnt_q[i] != num_q) begin
              // Data comparison only applies to write-then-verify (modes 2/3).
              if (mode_q[1] && (ctrl_rd_data_i[i*DATA_W +: DATA_W] != exp_q[i])) ch_err = 1'b1;
              rd_cnt_d[i] = rd_cnt_q[i] + CNT_W'(1);
              exp_d[i]    = pat_next(pattern_q, exp_q[i]);
            end else begin
              ch_err = 1'b1;
            end
          end
          if (ch_err) begin
            err_add = err_add + CNT_W'(1);
            if (!err_hit) begin
              err_hit = 1'b1;
              hit_ch  = CH_W'(i);
              hit_idx = rd_cnt_q[i];
            end
          end
        end
        // The count saturates and never wraps, so zero means no error recorded yet.
        if (err_hit && (err_count_q == '0)) begin
          first_ch_d  = hit_ch;
          first_idx_d = hit_idx;
        end
        sat_sum     = {1'b0, err_count_q} + {1'b0, err_add};
        err_count_d = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
        tmo_cnt_d   = tmo_cnt_q + CNT_W'(1);
        if (all_done) begin
          state_d = S_FINISH;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_count_q == '0) && !timeout_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      pattern_q   <= '0;
      mask_q      <= '0;
      addr_q      <= '0;
      num_q       <= '0;
      lat_q       <= '0;
      ctrl_mode_q <= '0;
      wr_pat_q    <= '0;
      wr_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
      first_ch_q  <= '0;
      first_idx_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rd_cnt_q[i] <= '0;
        exp_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pattern_q   <= pattern_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      num_q       <= num_d;
      lat_q       <= lat_d;
      ctrl_mode_q <= ctrl_mode_d;
      wr_pat_q    <= wr_pat_d;
      wr_cnt_q    <= wr_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
      first_ch_q  <= first_ch_d;
      first_idx_q <= first_idx_d;
      for (int i = 0; i < NUM_CH; i++) begin
        rd_cnt_q[i] <= rd_cnt_d[i];
        exp_q[i]    <= exp_d[i];
      end
    end
  end

  // Strobes decode straight from the state so an asynchronous reset drops them at once.
  assign ctrl_cs_o            = ((state_q == S_WR_CMD) || (state_q == S_RD_CMD)) ? mask_q : '0;
  assign ctrl_wr_data_valid_o = (state_q == S_WR_DATA);
  assign ctrl_wr_data_o       = (state_q == S_WR_DATA) ? wr_pat_q : '0;
  assign ctrl_mode_o          = ctrl_mode_q;
  assign ctrl_addr_o          = addr_q;
  assign ctrl_num_words_o     = num_q;
  assign ctrl_latency_o       = lat_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign pass_o               = pass_q;
  assign timeout_o            = timeout_q;
  assign err_count_o          = err_count_q;
  assign first_err_ch_o       = first_ch_q;
  assign first_err_idx_o      = first_idx_q;

endmodule

// File: tb/tb_hyperram_traffic_gen.sv
// tb/tb_hyperram_traffic_gen.sv - self-checking bench for hyperram_traffic_gen
module tb_hyperram_traffic_gen;

  localparam int          NUM_CH = 4;
  localparam int          DATA_W = 32;
  localparam int          CNT_W  = 32;
  localparam logic [31:0] TAPS   = 32'h80200003;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic [1:0]               cfg_mode = '0;
  logic [1:0]               cfg_pattern = '0;
  logic [DATA_W-1:0]        cfg_seed = '0;
  logic [NUM_CH-1:0]        cfg_ch_mask = '0;
  logic [CNT_W-1:0]         cfg_addr = '0;
  logic [CNT_W-1:0]         cfg_num_words = '0;
  logic [2:0]               cfg_latency = '0;
  logic [NUM_CH-1:0]        ctrl_cs;
  logic [1:0]               ctrl_mode;
  logic [CNT_W-1:0]         ctrl_addr;
  logic [CNT_W-1:0]         ctrl_num_words;
  logic [2:0]               ctrl_latency;
  logic [DATA_W-1:0]        ctrl_wr_data;
  logic                     ctrl_wr_data_valid;
  logic [NUM_CH*DATA_W-1:0] rd_data = '0;
  logic [NUM_CH-1:0]        rd_valid = '0;
  logic                     busy, done, pass, timeout;
  logic [CNT_W-1:0]         err_count;
  logic [1:0]               first_err_ch;
  logic [CNT_W-1:0]         first_err_idx;

  always #5 clk = ~clk;

  hyperram_traffic_gen #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .GAP_CYCLES(8), .TIMEOUT(200), .LFSR_TAPS(TAPS)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .abort_i(abort),
    .cfg_mode_i(cfg_mode), .cfg_pattern_i(cfg_pattern), .cfg_seed_i(cfg_seed),
    .cfg_ch_mask_i(cfg_ch_mask), .cfg_addr_i(cfg_addr), .cfg_num_words_i(cfg_num_words),
    .cfg_latency_i(cfg_latency),
    .ctrl_cs_o(ctrl_cs), .ctrl_mode_o(ctrl_mode), .ctrl_addr_o(ctrl_addr),
    .ctrl_num_words_o(ctrl_num_words), .ctrl_latency_o(ctrl_latency),
    .ctrl_wr_data_o(ctrl_wr_data), .ctrl_wr_data_valid_o(ctrl_wr_data_valid),
    .ctrl_rd_data_i(rd_data), .ctrl_rd_data_valid_i(rd_valid),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .err_count_o(err_count), .first_err_ch_o(first_err_ch), .first_err_idx_o(first_err_idx)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  pat;
    logic [31:0] seed;
    logic [3:0]  mask;
    int          num;
    logic [31:0] ret;       // words returned per channel, byte per channel
    logic [31:0] skew;      // read start delay per channel, byte per channel
    logic [3:0]  flip_mask; // channels whose word flip_idx gets bit 0 flipped
    int          flip_idx;
    int          exp_err;
    int          exp_fch;
    int          exp_fidx;
    bit          exp_pass;
    bit          exp_tmo;
    int          exp_cs;
    int          exp_wr;
    int          exp_done_lat;  // 0 = not checked
    int          exp_rd_to_done; // 0 = not checked
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  string       tag = "init";
  vec_t        vecs[9];
  vec_t        exp_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] w0, w1;

  function automatic vec_t mk(logic [1:0] mode, logic [1:0] pat, logic [31:0] seed, logic [3:0] mask,
                              int num, logic [31:0] ret, logic [31:0] skew, logic [3:0] fm, int fi,
                              int ee, int efc, int efi, bit ep, bit et, int ecs, int ewr, int edl, int erd);
    vec_t v;
    v.mode = mode; v.pat = pat; v.seed = seed; v.mask = mask; v.num = num; v.ret = ret; v.skew = skew;
    v.flip_mask = fm; v.flip_idx = fi; v.exp_err = ee; v.exp_fch = efc; v.exp_fidx = efi;
    v.exp_pass = ep; v.exp_tmo = et; v.exp_cs = ecs; v.exp_wr = ewr; v.exp_done_lat = edl;
    v.exp_rd_to_done = erd;
    return v;
  endfunction

  function automatic logic [31:0] pat_word(logic [1:0] p, logic [31:0] s, int k);
    logic [31:0] x;
    if (p == 2'd0) return s;
    if (p == 2'd1) return s + 32'(k);
    x = (s == 32'd0) ? 32'd1 : s;
    for (int j = 0; j < k; j++) x = (x >> 1) ^ (x[0] ? TAPS : 32'd0);
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s_%s actual=0x%0h required=0x%0h", tag, name, act, req);
    end
  endtask

  task automatic check_all_zero();
    check("zero_ctrl", {60'd0, ctrl_cs}, 64'd0);
    check("zero_strobes", {ctrl_mode, ctrl_wr_data_valid, ctrl_latency}, 64'd0);
    check("zero_addr_num", {ctrl_addr, ctrl_num_words}, 64'd0);
    check("zero_wr_data", {32'd0, ctrl_wr_data}, 64'd0);
    check("zero_status", {busy, done, pass, timeout, first_err_ch}, 64'd0);
    check("zero_counts", {err_count, first_err_idx}, 64'd0);
  endtask

  task automatic pulse_start(input logic [1:0] mode, input logic [1:0] pat, input logic [31:0] seed,
                             input logic [3:0] mask, input int num);
    @(negedge clk);
    cfg_mode = mode; cfg_pattern = pat; cfg_seed = seed; cfg_ch_mask = mask;
    cfg_num_words = 32'(num); cfg_addr = 32'h4000_0000 + 32'(num); cfg_latency = 3'd5;
    start = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, output logic [31:0] m0, output logic [31:0] m1);
    int cyc, rd_cmd_cyc, cs_cnt, wr_cnt, rel, k;
    bit got_done;
    vec_t e;
    logic [31:0] mem [64];
    for (int j = 0; j < 64; j++) mem[j] = 32'd0;
    pulse_start(v.mode, v.pat, v.seed, v.mask, v.num);
    exp_q.push_back(v);
    if (v.mode != 2'd1 && v.mask != 4'd0 && v.num != 0)
      for (int j = 0; j < v.num; j++) wr_q.push_back(pat_word(v.pat, v.seed, j));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    cyc = 1; rd_cmd_cyc = -1; cs_cnt = 0; wr_cnt = 0; got_done = 1'b0;
    while (!got_done && cyc < 3000) begin
      if (ctrl_cs != 4'd0) begin
        cs_cnt++;
        check("cs_mask", {60'd0, ctrl_cs}, {60'd0, v.mask});
        check("cmd_fields", {ctrl_addr, 29'd0, ctrl_latency}, {32'h4000_0000 + 32'(v.num), 32'd5});
        if (ctrl_mode == 2'b01) rd_cmd_cyc = cyc;
      end
      if (ctrl_wr_data_valid) begin
        if (wr_q.size() == 0) check("wr_extra_word", 64'd1, 64'd0);
        else check("wr_data", {32'd0, ctrl_wr_data}, {32'd0, wr_q.pop_front()});
        if (wr_cnt < 64) mem[wr_cnt] = ctrl_wr_data;
        wr_cnt++;
      end
      rd_valid = '0;
      rd_data  = '0;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (rd_cmd_cyc >= 0) begin
          rel = cyc - rd_cmd_cyc - 1;
          for (int ch = 0; ch < NUM_CH; ch++) begin
            k = rel - int'(v.skew[8*ch +: 8]);
            if (k >= 0 && k < int'(v.ret[8*ch +: 8])) begin
              rd_valid[ch] = 1'b1;
              rd_data[ch*DATA_W +: DATA_W] = mem[k % 64] ^
                  ((v.flip_mask[ch] && k == v.flip_idx) ? 32'd1 : 32'd0);
            end
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    rd_valid = '0;
    rd_data  = '0;
    m0 = mem[0];
    m1 = mem[1];
    if (!got_done) begin
      check("done_within_budget", 64'd0, 64'd1);
      exp_q.delete();
      wr_q.delete();
    end else if (exp_q.size() == 0) begin
      check("scoreboard_entry", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("err_count", {32'd0, err_count}, 64'(e.exp_err));
      check("first_err_ch", {62'd0, first_err_ch}, 64'(e.exp_fch));
      check("first_err_idx", {32'd0, first_err_idx}, 64'(e.exp_fidx));
      check("pass", {63'd0, pass}, {63'd0, e.exp_pass});
      check("timeout", {63'd0, timeout}, {63'd0, e.exp_tmo});
      check("busy_at_done", {63'd0, busy}, 64'd0);
      check("cs_pulses", 64'(cs_cnt), 64'(e.exp_cs));
      check("wr_words", 64'(wr_cnt), 64'(e.exp_wr));
      if (e.exp_done_lat != 0) check("done_latency", 64'(cyc), 64'(e.exp_done_lat));
      if (e.exp_rd_to_done != 0) check("rd_to_done", 64'(cyc - rd_cmd_cyc), 64'(e.exp_rd_to_done));
      @(negedge clk);
      check("done_one_cycle", {63'd0, done}, 64'd0);
      check("status_hold", {31'd0, pass, err_count}, {31'd0, e.exp_pass, 32'(e.exp_err)});
    end
  endtask

  initial begin
    int  idx;
    bit  found, seen;
    //          mode pat seed          mask num ret           skew          fm    fi ee fch fidx pass tmo cs wr  dl  rd
    vecs[0] = mk(2, 1, 32'h100,      4'hF, 16, 32'h10101010, 32'h00000000, 4'h0, 0, 0, 0, 0,   1, 0,  2, 16, 0, 0);
    vecs[1] = mk(2, 2, 32'h0,        4'h5, 8,  32'h08080808, 32'h00000000, 4'h4, 5, 1, 2, 5,   0, 0,  2, 8,  0, 0);
    vecs[2] = mk(1, 0, 32'h0,        4'h3, 8,  32'h00000708, 32'h00000000, 4'h0, 0, 0, 0, 0,   0, 1,  1, 0,  0, 202);
    vecs[3] = mk(2, 1, 32'h55,       4'h9, 8,  32'h0A000008, 32'h00000003, 4'h0, 0, 2, 3, 8,   0, 0,  2, 8,  0, 0);
    vecs[4] = mk(2, 1, 32'h1,        4'hF, 0,  32'h00000000, 32'h00000000, 4'h0, 0, 0, 0, 0,   1, 0,  0, 0,  2, 0);
    vecs[5] = mk(2, 1, 32'h1,        4'h0, 4,  32'h04040404, 32'h00000000, 4'h0, 0, 0, 0, 0,   1, 0,  0, 0,  2, 0);
    vecs[6] = mk(0, 0, 32'hDEADBEEF, 4'h2, 4,  32'h00000000, 32'h00000000, 4'h0, 0, 0, 0, 0,   1, 0,  1, 4,  0, 0);
    vecs[7] = mk(3, 3, 32'hACE1,     4'hF, 5,  32'h05050505, 32'h04020100, 4'h0, 0, 0, 0, 0,   1, 0,  2, 5,  0, 0);
    vecs[8] = mk(2, 0, 32'h0F0F0F0F, 4'hF, 4,  32'h04040404, 32'h00000000, 4'hA, 2, 2, 1, 2,   0, 0,  2, 4,  0, 0);

    tag = "reset";
    repeat (3) @(negedge clk);
    check_all_zero();
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      tag = $sformatf("v%0d", i);
      run_vec(vecs[i], w0, w1);
      if (i == 1) begin
        check("lfsr_word0", {32'd0, w0}, 64'd1);
        check("lfsr_word1", {32'd0, w1}, 64'h80200003);
      end
    end

    tag = "abort";
    pulse_start(2'd2, 2'd1, 32'h200, 4'hF, 16);
    @(negedge clk);
    start = 1'b0;
    found = 1'b0; idx = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (ctrl_wr_data_valid) begin
        if (idx == 3) found = 1'b1;
        else idx++;
      end
    end
    check("reach_word3", {63'd0, found}, 64'd1);
    check("word3_data", {32'd0, ctrl_wr_data}, 64'h203);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("valid_drop", {63'd0, ctrl_wr_data_valid}, 64'd0);
    check("busy_drop", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (done || ctrl_cs != 4'd0 || ctrl_wr_data_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("quiet_after_abort", {63'd0, seen}, 64'd0);
    check("pass_after_abort", {63'd0, pass}, 64'd0);
    tag = "after_abort";
    run_vec(vecs[0], w0, w1);

    tag = "midrun_reset";
    pulse_start(2'd2, 2'd1, 32'h300, 4'hF, 16);
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (ctrl_cs != 4'd0 && ctrl_mode == 2'b01) found = 1'b1;
    end
    check("reach_rd_cmd", {63'd0, found}, 64'd1);
    repeat (2) @(negedge clk);
    check("busy_in_rd_data", {63'd0, busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1 check_all_zero();
    @(negedge clk);
    reset_n = 1'b1;
    tag = "after_reset";
    run_vec(vecs[0], w0, w1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
